// File: rtl/da_engine_if.sv
// da_engine bus bundle: coefficient port, slice handshake, result.
// Clock and reset are routed separately as plain ports.
interface da_engine_if #(
  parameter int NBANK  = 8,
  parameter int LUT_AW = 8,
  parameter int CW     = 20,
  parameter int BITS   = 16
);
  localparam int TL = $clog2(NBANK);
  localparam int AW = CW + TL + BITS;

  logic                    cload;
  logic [TL+LUT_AW-1:0]    caddr;
  logic [CW-1:0]           cin;
  logic                    start;
  logic                    valid_in;
  logic [NBANK*LUT_AW-1:0] addr_in;
  logic                    ready;
  logic                    busy;
  logic [AW-1:0]           acc_out;
  logic                    valid_out;

  modport master (
    output cload, caddr, cin,
    output start, valid_in, addr_in,
    input  ready, busy, acc_out, valid_out
  );

  modport slave (
    input  cload, caddr, cin,
    input  start, valid_in, addr_in,
    output ready, busy, acc_out, valid_out
  );
endinterface

// File: rtl/da_engine.sv
// Distributed-arithmetic inner-product engine: LUT banks, adder tree, MSB-first accumulator.
// DA_SIGNED_EN: treat input samples as two's complement (MSB slice negated).
module da_engine #(
  parameter int NBANK  = 8,
  parameter int LUT_AW = 8,
  parameter int CW     = 20,
  parameter int BITS   = 16
) (
  input logic      clk,
  input logic      resetn,
  da_engine_if.slave bus
);
  localparam int TL   = $clog2(NBANK);
  localparam int SW   = CW + TL;
  localparam int AW   = SW + BITS;
  localparam int CNTW = $clog2(BITS + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t r_state, w_next;
  logic   w_ready, w_busy, w_acc, w_wr;

  logic [CW-1:0]        r_lut [NBANK][2**LUT_AW];
  logic [CW-1:0]        w_rd  [NBANK];
  logic signed [SW-1:0] r_t   [TL+1][NBANK];
  logic [TL:0]          r_v;
  logic [CNTW-1:0]      r_scnt, r_acnt;
  logic [AW-1:0]        r_acc, r_out, w_sx;
  logic                 r_fin, r_vout;

  assign w_acc = bus.valid_in && w_ready;
  assign w_wr  = bus.cload && (r_state == IDLE) && resetn;
  assign w_sx  = {{BITS{r_t[TL][0][SW-1]}}, r_t[TL][0]};

  assign bus.ready     = w_ready;
  assign bus.busy      = w_busy;
  assign bus.acc_out   = r_out;
  assign bus.valid_out = r_vout;

  // LUT contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr)
      r_lut[bus.caddr[TL+LUT_AW-1:LUT_AW]][bus.caddr[LUT_AW-1:0]] <= bus.cin;
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++)
      w_rd[b] = r_lut[b][bus.addr_in[b*LUT_AW +: LUT_AW]];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++)
      r_t[0][b] <= {{TL{w_rd[b][CW-1]}}, w_rd[b]};
  end

  for (genvar k = 1; k <= TL; k++) begin : g_lvl
    for (genvar i = 0; i < NBANK; i++) begin : g_node
      if (i < (NBANK >> k)) begin : g_add
        always_ff @(posedge clk)
          r_t[k][i] <= r_t[k-1][2*i] + r_t[k-1][2*i+1];
      end else begin : g_nil
        always_ff @(posedge clk)
          r_t[k][i] <= '0;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = RUN;
      end
      RUN: begin
        w_ready = 1'b1;
        if (bus.valid_in && r_scnt == LAST)
          w_next = DRAIN;
      end
      DRAIN: begin
        if (r_fin) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_v     <= '0;
      r_scnt  <= '0;
      r_acnt  <= '0;
      r_acc   <= '0;
      r_fin   <= 1'b0;
      r_out   <= '0;
      r_vout  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_v     <= {r_v[TL-1:0], w_acc};
      if (r_state == IDLE && bus.start) begin
        r_scnt <= '0;
        r_acnt <= '0;
        r_acc  <= '0;
      end else begin
        if (w_acc) r_scnt <= r_scnt + 1'b1;
        if (r_v[TL]) begin
          r_acnt <= r_acnt + 1'b1;
          if (r_acnt == '0)
`ifdef DA_SIGNED_EN
            r_acc <= '0 - w_sx;
`else
            r_acc <= w_sx;
`endif
          else
            r_acc <= (r_acc << 1) + w_sx;
        end
      end
      r_fin  <= r_v[TL] && (r_acnt == LAST);
      r_vout <= r_fin;
      if (r_fin) r_out <= r_acc;
    end
  end
endmodule

// File: tb/tb_da_engine.sv
// Randomized bench for da_engine with a weighted-sum reference model.
// Build with DA_SIGNED_EN to check the two's complement variant.
module tb_da_engine;
  localparam int NBANK  = 8;
  localparam int LUT_AW = 8;
  localparam int CW     = 20;
  localparam int BITS   = 16;
  localparam int AW     = 39;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  da_engine_if #(
    .NBANK(NBANK), .LUT_AW(LUT_AW), .CW(CW), .BITS(BITS)
  ) bus ();

  da_engine #(
    .NBANK(NBANK), .LUT_AW(LUT_AW), .CW(CW), .BITS(BITS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint        due;
    logic [AW-1:0] val;
  } exp_t;

  exp_t          q[$];
  int            nchk = 0;
  int            nerr = 0;
  longint        cyc = 0;
  logic [AW-1:0] exp_acc = '0;
  int            lutm [NBANK][256];
  logic [63:0]   slices [BITS];

`ifdef DA_SIGNED_EN
  localparam logic [AW-1:0] L_SINGLE = 39'h7F_FFFF_FFFB;
  localparam logic [AW-1:0] L_FULL   = 39'd8;
`else
  localparam logic [AW-1:0] L_SINGLE = 39'd327675;
  localparam logic [AW-1:0] L_FULL   = 39'h7F_FFF8_0008;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // result = sum over slices of (bank sum) * 2^(BITS-1-j), MSB weight negated if signed
  function automatic logic [AW-1:0] model();
    longint tot = 0;
    for (int j = 0; j < BITS; j++) begin
      longint s = 0;
      longint w;
      for (int b = 0; b < NBANK; b++)
        s += longint'(lutm[b][slices[j][b*LUT_AW +: LUT_AW]]);
      w = longint'(1) << (BITS - 1 - j);
`ifdef DA_SIGNED_EN
      if (j == 0) w = -w;
`endif
      tot += s * w;
    end
    return AW'(tot);
  endfunction

  always @(negedge clk) begin
    logic ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("valid_out", 64'(bus.valid_out), 64'(ev));
    if (ev) begin
      exp_acc = q[0].val;
      q.delete(0);
    end
    chk("acc_out", 64'(bus.acc_out), 64'(exp_acc));
    if (q.size() > 0 && q[0].due < cyc) begin
      nchk++;
      nerr++;
      $display("FAIL result_missing: due cycle %0d passed", q[0].due);
      q.delete(0);
    end
  end

  task automatic drv_idle();
    bus.cload    = 1'b0;
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.caddr    = '0;
    bus.cin      = '0;
    bus.addr_in  = '0;
  endtask

  task automatic wr(int b, int e, int v);
    @(posedge clk);
    #1;
    drv_idle();
    bus.cload = 1'b1;
    bus.caddr = {3'(b), 8'(e)};
    bus.cin   = 20'(v);
    lutm[b][e] = v;
  endtask

  task automatic wr_end();
    @(posedge clk);
    #1;
    drv_idle();
  endtask

  function automatic int rval();
    return int'($urandom_range(0, 32'hFFFFF)) - 524288;
  endfunction

  // mode: 0 back-to-back, 1 alternate bubbles, 2 random bubbles
  task automatic run(int mode, bit coload, bit ign, int abort_at);
    int acc = 0;
    int it  = 0;
    bit v;
    @(posedge clk);
    #1;
    drv_idle();
    bus.start = 1'b1;
    chk("ready_idle", 64'(bus.ready), 64'd0);
    if (coload) begin
      int b = $urandom_range(0, NBANK - 1);
      int e = $urandom_range(0, 255);
      int x = rval();
      bus.cload = 1'b1;
      bus.caddr = {3'(b), 8'(e)};
      bus.cin   = 20'(x);
      lutm[b][e] = x;
    end
    while (acc < BITS && it < 200) begin
      @(posedge clk);
      #1;
      drv_idle();
      it++;
      chk("busy_run", 64'(bus.busy), 64'd1);
      chk("ready_run", 64'(bus.ready), 64'd1);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (it % 2) == 1;
      else v = 1'($urandom_range(0, 1));
      if (ign && acc == 8) begin
        bus.start = 1'b1;
        bus.cload = 1'b1;
        bus.caddr = {3'd0, slices[0][7:0]};
        bus.cin   = 20'h12345;
      end
      bus.valid_in = v;
      bus.addr_in  = slices[acc];
      if (v) begin
        if (acc == BITS - 1)
          q.push_back('{due: cyc + 6, val: model()});
        acc++;
      end
      if (abort_at > 0 && acc == abort_at) break;
    end
    if (it >= 200) begin
      nchk++;
      nerr++;
      $display("FAIL run_timeout: accepted %0d slices", acc);
    end
    @(posedge clk);
    #1;
    drv_idle();
    if (abort_at == 0) begin
      chk("ready_drain", 64'(bus.ready), 64'd0);
      chk("busy_drain", 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL result_timeout: %0d results pending", q.size());
      q.delete();
    end
    #1;
    chk("busy_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic rand_slices();
    for (int j = 0; j < BITS; j++)
      slices[j] = {$urandom, $urandom};
  endtask

  initial begin
    drv_idle();
    resetn = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.cload    = 1'($urandom_range(0, 1));
      bus.start    = 1'($urandom_range(0, 1));
      bus.valid_in = 1'($urandom_range(0, 1));
      bus.addr_in  = {$urandom, $urandom};
      bus.caddr    = 11'($urandom);
      bus.cin      = 20'($urandom);
      chk("rst_ready", 64'(bus.ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
    end
    @(posedge clk);
    #1;
    drv_idle();
    resetn = 1'b1;

    wr(2, 3, 7);
    wr_end();
    chk("cload_only_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk("cload_only_busy2", 64'(bus.busy), 64'd0);

    for (int b = 0; b < NBANK; b++)
      for (int e = 0; e < 256; e++)
        wr(b, e, 0);
    wr(0, 1, 5);
    wr_end();

    for (int j = 0; j < BITS; j++) slices[j] = 64'h1;
    chk("model_single", 64'(model()), 64'(L_SINGLE));
    run(0, 1'b0, 1'b0, 0);
    wait_done();
    chk("single_term", 64'(bus.acc_out), 64'(L_SINGLE));

    run(1, 1'b0, 1'b0, 0);
    wait_done();
    chk("single_bubbles", 64'(bus.acc_out), 64'(L_SINGLE));

    for (int b = 0; b < NBANK; b++) wr(b, 255, -1);
    wr_end();
    for (int j = 0; j < BITS; j++) slices[j] = '1;
    chk("model_full", 64'(model()), 64'(L_FULL));
    run(0, 1'b0, 1'b0, 0);
    wait_done();
    chk("full_tree", 64'(bus.acc_out), 64'(L_FULL));

    run(0, 1'b0, 1'b0, 7);
    resetn = 1'b0;
    q.delete();
    exp_acc = '0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_ready", 64'(bus.ready), 64'd0);
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle", 64'(bus.busy), 64'd0);
    run(0, 1'b0, 1'b0, 0);
    wait_done();
    chk("after_abort", 64'(bus.acc_out), 64'(L_FULL));

    repeat (30) wr($urandom_range(0, NBANK - 1), $urandom_range(0, 255), rval());
    wr_end();
    rand_slices();
    run(0, 1'b0, 1'b1, 0);
    wait_done();
    run(2, 1'b0, 1'b0, 0);
    wait_done();

    repeat (6) begin
      repeat (20) wr($urandom_range(0, NBANK - 1), $urandom_range(0, 255), rval());
      wr_end();
      rand_slices();
      run(2, 1'b1, 1'b0, 0);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/da_engine.md
# da_engine

Parametrised distributed-arithmetic (DA) inner-product engine, the successor to the fixed 8-bank DA core. It holds NBANK coefficient look-up tables (LUTs), loaded through a coefficient port. Each input bit-slice addresses all banks, and the bank outputs are summed in a registered balanced adder tree, which accepts one slice per cycle. Slices arrive MSB first, and a shift-accumulator folds them into one AW-bit result per BITS slices. The block sits between the FIR tap-delay/bit-serialiser and the output formatter.

## Interface
Parameters:
- NBANK, 8, number of LUT banks; power of two, 2..16; TL = log2(NBANK)
- LUT_AW, 8, LUT address width per bank (2^LUT_AW entries per bank)
- CW, 20, LUT entry width, signed two's complement
- BITS, 16, slices per result (input sample word length)
- AW (localparam), CW+TL+BITS, accumulator/result width

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cload  in  1  coefficient write strobe
- caddr  in  TL+LUT_AW  upper TL bits select the bank; lower LUT_AW bits select the entry
- cin  in  CW  coefficient write data
- start  in  1  begins a result computation
- valid_in  in  1  addr_in carries a slice
- addr_in  in  NBANK*LUT_AW  bank b address = addr_in[b*LUT_AW +: LUT_AW]
- ready  out  1  slice accepted when valid_in && ready
- busy  out  1  high outside IDLE
- acc_out  out  AW  last completed result; held until the next result
- valid_out  out  1  one-cycle pulse when acc_out updates

## Operation
- States:
  - IDLE: busy=0, ready=0.
  - RUN: ready=1 while accepted-slice count < BITS.
  - DRAIN: ready=0; waits for the pipeline to empty.
- Transitions:
  - IDLE→RUN on start. start clears the slice counter and the accumulator.
  - RUN→DRAIN on acceptance of slice BITS-1.
  - DRAIN→IDLE in the same cycle valid_out pulses.
- Coefficient writes:
  - A cload in IDLE writes cin to bank caddr[TL+LUT_AW-1:LUT_AW], entry caddr[LUT_AW-1:0], on the next edge.
  - cload outside IDLE is ignored.
  - LUT contents are not reset and are undefined until written.
- start outside IDLE is ignored. A start and a cload in the same IDLE cycle both take effect.
- valid_in with ready=0 is ignored. A valid_in=0 cycle in RUN inserts a bubble. Each pipeline stage carries a valid bit, so bubbles never alter the result.
- Datapath:
  - Registered LUT read (1 stage).
  - Tree of TL registered adder levels. Level k operands are sign-extended to CW+k bits; the final sum is CW+TL bits.
  - Accumulate stage: the first (MSB) slice gives acc = ±sum (see Configuration). Each later slice gives acc = (acc<<1) + sign-extended sum.
  - Accumulator arithmetic wraps modulo 2^AW, with no saturation.
- After the BITS-th slice's accumulate, acc_out is loaded and valid_out pulses.

## Timing
- Throughput: one slice per clock.
- Latency: acc_out/valid_out update TL+2 cycles after the edge that accepts the last slice. With default parameters this is 5 cycles.
- Next start is accepted the cycle after valid_out. Minimum result period is BITS+TL+3 cycles.
- Reset values: ready=0, busy=0, valid_out=0, acc_out=0. The FSM, counter, accumulator and pipeline valid bits are all cleared.
- Reset asserted mid-RUN/DRAIN aborts the computation. No valid_out is produced for the aborted result, and LUT contents are preserved.
- valid_out is never asserted in consecutive cycles.

## Configuration
- DA_SIGNED_EN defined: input samples are two's complement. The MSB slice carries weight −2^(BITS−1), so the first accumulate uses acc = −sum.
- DA_SIGNED_EN undefined: input samples are unsigned. The first accumulate uses acc = +sum.

## Test plan
All scenarios use default parameters unless stated.
- Reset: hold resetn=0 with random inputs → acc_out=0, valid_out=0, ready=0, busy=0. Release, then apply cload with no start → busy stays 0.
- Unsigned single term:
  - Setup: zero all LUTs, then write bank0[1]=5.
  - Stimulus: start, then 16 back-to-back slices with bank0 addr=1 and all other bank addresses 0.
  - Response: acc_out=327675, one valid_out pulse, 5 cycles after the last slice.
- Signed single term: same stimulus with DA_SIGNED_EN defined → acc_out = −5 (0x7F_FFFF_FFFB in 39 bits).
- Bubbles: repeat the unsigned single-term test with valid_in low on alternate cycles → same result; ready stays 1 until 16 slices are accepted.
- Full tree:
  - Setup: every bank entry 0xFF = −1.
  - Stimulus: all addresses 0xFF for 16 slices.
  - Response: unsigned gives acc_out = −524280 mod 2^39; signed gives acc_out = 8.
- Abort and ignore:
  - Assert resetn=0 after 7 slices → no valid_out, busy=0. A subsequent run gives the correct result.
  - start and cload pulsed during RUN → result unchanged and LUT unchanged.
